// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM state encoding shared by seq_alu and its iterative core.
// Revision 1.0
`default_nettype none

package alu_pkg;

   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_AND = 2;
   localparam int OP_OR  = 3;
   localparam int OP_MUL = 4;
   localparam int OP_DIV = 5;
   localparam int OP_SHL = 7;
   localparam int OP_SHR = 8;
   localparam int OP_ROL = 9;
   localparam int OP_ROR = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_iter_core.sv
// alu_iter_core: unsigned shift-add multiplier / restoring divider, one bit per clock.
// Revision 1.0
`default_nettype none

module alu_iter_core #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               mode,      // 0 multiply, 1 divide
   input  logic [WIDTH-1:0]   mag_a,
   input  logic [WIDTH-1:0]   mag_b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rem
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
   logic             mode_q, mode_d, run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] src_acc, src_lo, src_opnd;
   logic             src_mode;
   logic [WIDTH:0]   w_sum, w_shift, w_diff;
   logic             w_qbit;

   assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign prod = {acc_q, lo_q};
   assign quot = lo_q;
   assign rem  = acc_q;

   // The first iteration is taken on the start edge straight from the inputs,
   // so the core finishes WIDTH iterations after WIDTH-1 further clocks.
   always_comb begin
      src_acc  = start ? '0    : acc_q;
      src_lo   = start ? mag_a : lo_q;
      src_opnd = start ? mag_b : opnd_q;
      src_mode = start ? mode  : mode_q;

      w_sum   = {1'b0, src_acc} + (src_lo[0] ? {1'b0, src_opnd} : '0);
      w_shift = {src_acc, src_lo[WIDTH-1]};
      w_qbit  = (w_shift >= {1'b0, src_opnd});
      w_diff  = w_shift - {1'b0, src_opnd};

      acc_d  = acc_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      mode_d = mode_q;
      run_d  = run_q;
      cnt_d  = cnt_q;

      if (start || run_q) begin
         opnd_d = src_opnd;
         mode_d = src_mode;
         if (src_mode) begin
            acc_d = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            lo_d  = {src_lo[WIDTH-2:0], w_qbit};
         end else begin
            acc_d = w_sum[WIDTH:1];
            lo_d  = {w_sum[0], src_lo[WIDTH-1:1]};
         end
      end

      if (start) begin
         run_d = 1'b1;
         cnt_d = CNT_W'(1);
      end else if (run_q) begin
         if (done) begin
            run_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         mode_q <= 1'b0;
         run_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
         mode_q <= mode_d;
         run_q  <= run_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered outputs and iterative signed multiply/divide.
// Revision 1.0
`default_nettype none

module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [OPW-1:0]     opcode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [WIDTH-1:0]   remainder,
   output logic               overflow,
   output logic               div_zero,
   output logic               busy
);

   state_e             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               ovf_q, ovf_d, dz_q, dz_d;
   logic               neg_q, neg_d, sa_q, sa_d, mino_q, mino_d, isdiv_q, isdiv_d;

   logic               w_accept, core_start, core_mode, core_done;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, core_quot, core_rem, w_amt;
   logic [2*WIDTH-1:0] core_prod, w_sext_a, w_dbl, w_rol, w_ror, w_prod_s;
   logic [WIDTH:0]     w_add, w_sub, w_quot_s;
   logic [2*WIDTH-1:0] w_res1;
   logic [WIDTH-1:0]   w_rem1;
   logic               w_ovf1, w_dz1;

   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign remainder = rem_q;
   assign overflow  = ovf_q;
   assign div_zero  = dz_q;

   assign w_mag_a = a[WIDTH-1] ? -a : a;
   assign w_mag_b = b[WIDTH-1] ? -b : b;

   alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (core_start),
      .mode    (core_mode),
      .mag_a   (w_mag_a),
      .mag_b   (w_mag_b),
      .done    (core_done),
      .prod    (core_prod),
      .quot    (core_quot),
      .rem     (core_rem)
   );

   // Single-cycle results, computed from the live operands at accept.
   always_comb begin
      w_add    = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      w_sub    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      w_sext_a = {{WIDTH{a[WIDTH-1]}}, a};
      w_amt    = b % WIDTH'(WIDTH);
      w_dbl    = {a, a};
      w_rol    = w_dbl << w_amt;
      w_ror    = w_dbl >> w_amt;

      w_res1 = '0;
      w_rem1 = '0;
      w_ovf1 = 1'b1;
      w_dz1  = 1'b0;
      case (opcode)
         OPW'(OP_ADD): begin
            w_res1 = {{(WIDTH-1){w_add[WIDTH]}}, w_add};
            w_ovf1 = (w_add[WIDTH] == w_add[WIDTH-1]);
         end
         OPW'(OP_SUB): begin
            w_res1 = {{(WIDTH-1){w_sub[WIDTH]}}, w_sub};
            w_ovf1 = (w_sub[WIDTH] == w_sub[WIDTH-1]);
         end
         OPW'(OP_AND): w_res1 = {{WIDTH{a[WIDTH-1] & b[WIDTH-1]}}, a & b};
         OPW'(OP_OR):  w_res1 = {{WIDTH{a[WIDTH-1] | b[WIDTH-1]}}, a | b};
         OPW'(OP_DIV): begin
            w_res1 = '1;
            w_rem1 = a;
            w_ovf1 = 1'b0;
            w_dz1  = 1'b1;
         end
         OPW'(OP_SHL): w_res1 = (b >= WIDTH'(2*WIDTH)) ? '0 : (w_sext_a << b);
         OPW'(OP_SHR): w_res1 = (b >= WIDTH'(2*WIDTH)) ? '0 : (w_sext_a >> b);
         OPW'(OP_ROL): w_res1 = {{WIDTH{1'b0}}, w_rol[2*WIDTH-1:WIDTH]};
         OPW'(OP_ROR): w_res1 = {{WIDTH{1'b0}}, w_ror[WIDTH-1:0]};
         default: ;
      endcase
   end

   // Quotient magnitude may be 2^(WIDTH-1) (MIN/-1), so it is signed in WIDTH+1 bits.
   assign w_prod_s = neg_q ? -core_prod : core_prod;
   assign w_quot_s = neg_q ? -{1'b0, core_quot} : {1'b0, core_quot};

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      res_d       = res_q;
      rem_d       = rem_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      neg_d       = neg_q;
      sa_d        = sa_q;
      mino_d      = mino_q;
      isdiv_d     = isdiv_q;
      core_start  = 1'b0;
      core_mode   = 1'b0;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
               sa_d   = a[WIDTH-1];
               mino_d = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
               if (opcode == OPW'(OP_MUL)) begin
                  state_d    = MUL;
                  core_start = 1'b1;
                  isdiv_d    = 1'b0;
               end else if ((opcode == OPW'(OP_DIV)) && (b != '0)) begin
                  state_d    = DIV;
                  core_start = 1'b1;
                  core_mode  = 1'b1;
                  isdiv_d    = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  res_d       = w_res1;
                  rem_d       = w_rem1;
                  ovf_d       = w_ovf1;
                  dz_d        = w_dz1;
               end
            end
         end
         MUL, DIV: begin
            if (core_done) state_d = FIX;
         end
         FIX: begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
            dz_d        = 1'b0;
            if (isdiv_q) begin
               res_d = {{(WIDTH-1){w_quot_s[WIDTH]}}, w_quot_s};
               rem_d = sa_q ? -core_rem : core_rem;
               ovf_d = !mino_q;
            end else begin
               res_d = w_prod_s;
               rem_d = '0;
               ovf_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         rem_q       <= '0;
         ovf_q       <= 1'b1;
         dz_q        <= 1'b0;
         neg_q       <= 1'b0;
         sa_q        <= 1'b0;
         mino_q      <= 1'b0;
         isdiv_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         rem_q       <= rem_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
         neg_q       <= neg_d;
         sa_q        <= sa_d;
         mino_q      <= mino_d;
         isdiv_q     <= isdiv_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus handshake, stall, busy and reset sequences for seq_alu.
// Revision 1.0
`default_nettype none

module tb_seq_alu;

   localparam int W = 16;

   logic          clk, reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, remainder;
   logic [3:0]    opcode;
   logic [2*W-1:0] result;
   logic          overflow, div_zero, busy;

   int tests = 0;
   int fails = 0;

   seq_alu #(.WIDTH(W), .OPW(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .remainder (remainder),
      .overflow  (overflow),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [3:0]     op;
      logic [2*W-1:0] res;
      logic [W-1:0]   rem;
      logic           ovf;
      logic           dz;
      int             lat;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int busy_bad;
      string tag;
      tag = $sformatf("v%0d", idx);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = v.a; b = v.b; opcode = v.op;
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~v.a; b = ~v.b; opcode = 4'd3;
      lat = 1;
      busy_bad = 0;
      while (!out_valid && lat < 60) begin
         if (busy !== 1'b1) busy_bad++;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(v.lat));
      if (v.lat > 1) check({tag, ".busy_low_cycles"}, 64'(busy_bad), 64'd0);
      check({tag, ".result"}, 64'(result), 64'(v.res));
      check({tag, ".remainder"}, 64'(remainder), 64'(v.rem));
      check({tag, ".overflow"}, 64'(overflow), 64'(v.ovf));
      check({tag, ".div_zero"}, 64'(div_zero), 64'(v.dz));
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check({name, ".out_valid_timeout"}, 64'(out_valid), 64'd1);
   endtask

   initial begin
      int seen;
      logic [W-1:0] ea, eb;

      vecs[0]  = '{16'h7FFF, 16'h0001, 4'd0,  32'h00008000, 16'h0000, 1'b0, 1'b0, 1};
      vecs[1]  = '{16'hFFFB, 16'h0003, 4'd1,  32'hFFFFFFF8, 16'h0000, 1'b1, 1'b0, 1};
      vecs[2]  = '{16'hFED4, 16'h00C8, 4'd4,  32'hFFFF15A0, 16'h0000, 1'b1, 1'b0, 17};
      vecs[3]  = '{16'hFFF9, 16'h0002, 4'd5,  32'hFFFFFFFD, 16'hFFFF, 1'b1, 1'b0, 17};
      vecs[4]  = '{16'h0005, 16'h0000, 4'd5,  32'hFFFFFFFF, 16'h0005, 1'b0, 1'b1, 1};
      vecs[5]  = '{16'h8001, 16'h0011, 4'd9,  32'h00000003, 16'h0000, 1'b1, 1'b0, 1};
      vecs[6]  = '{16'h0001, 16'h0001, 4'd11, 32'h00008000, 16'h0000, 1'b1, 1'b0, 1};
      vecs[7]  = '{16'h0001, 16'h0028, 4'd7,  32'h00000000, 16'h0000, 1'b1, 1'b0, 1};
      vecs[8]  = '{16'h8000, 16'hFFFF, 4'd5,  32'h00008000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[9]  = '{16'hF0F0, 16'h0FF0, 4'd2,  32'h000000F0, 16'h0000, 1'b1, 1'b0, 1};
      vecs[10] = '{16'h8000, 16'h0001, 4'd3,  32'hFFFF8001, 16'h0000, 1'b1, 1'b0, 1};
      vecs[11] = '{16'h8000, 16'h0004, 4'd8,  32'h0FFFF800, 16'h0000, 1'b1, 1'b0, 1};
      vecs[12] = '{16'h1234, 16'h5678, 4'd6,  32'h00000000, 16'h0000, 1'b1, 1'b0, 1};
      vecs[13] = '{16'h8000, 16'hFFFF, 4'd0,  32'hFFFF7FFF, 16'h0000, 1'b0, 1'b0, 1};
      vecs[14] = '{16'h0007, 16'hFFFE, 4'd5,  32'hFFFFFFFD, 16'h0001, 1'b1, 1'b0, 17};
      vecs[15] = '{16'h8000, 16'h8000, 4'd4,  32'h40000000, 16'h0000, 1'b1, 1'b0, 17};
      vecs[16] = '{16'hFFFF, 16'h001F, 4'd7,  32'h80000000, 16'h0000, 1'b1, 1'b0, 1};
      vecs[17] = '{16'h1234, 16'h0020, 4'd8,  32'h00000000, 16'h0000, 1'b1, 1'b0, 1};
      vecs[18] = '{16'h0001, 16'h0010, 4'd11, 32'h00000001, 16'h0000, 1'b1, 1'b0, 1};
      vecs[19] = '{16'h7FFF, 16'hFFFF, 4'd1,  32'h00008000, 16'h0000, 1'b0, 1'b0, 1};
      vecs[20] = '{16'h7FFF, 16'hFFFF, 4'd4,  32'hFFFF8001, 16'h0000, 1'b1, 1'b0, 17};
      vecs[21] = '{16'hFFF8, 16'hFFFD, 4'd5,  32'h00000002, 16'hFFFE, 1'b1, 1'b0, 17};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; opcode = '0;
      repeat (2) @(negedge clk);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.result", 64'(result), 64'd0);
      check("rst.remainder", 64'(remainder), 64'd0);
      check("rst.overflow", 64'(overflow), 64'd1);
      check("rst.div_zero", 64'(div_zero), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

      // Back-to-back accepts with the consumer always ready: one result per cycle.
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd0;
      a = 16'd1; b = 16'd5;
      for (int k = 0; k < 4; k++) begin
         ea = a; eb = b;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("b2b%0d.out_valid", k), 64'(out_valid), 64'd1);
         check($sformatf("b2b%0d.result", k), 64'(result), 64'(32'(ea + eb)));
         a = 16'(3*k + 4); b = 16'(k + 6);
      end
      in_valid = 1'b0;
      @(negedge clk);

      // Consumer stall: outputs hold and the pending op is refused until released.
      out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd0; a = 16'd10; b = 16'd20;
      @(posedge clk);
      @(negedge clk);
      opcode = 4'd1; a = 16'd7; b = 16'd2;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall%0d.out_valid", k), 64'(out_valid), 64'd1);
         check($sformatf("stall%0d.result", k), 64'(result), 64'd30);
         check($sformatf("stall%0d.in_ready", k), 64'(in_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("stall.reload_valid", 64'(out_valid), 64'd1);
      check("stall.reload_result", 64'(result), 64'd5);
      @(posedge clk);
      @(negedge clk);
      check("stall.drained", 64'(out_valid), 64'd0);

      // New requests while the multiplier is busy are not accepted.
      in_valid = 1'b1; opcode = 4'd4; a = 16'd3; b = 16'd4;
      @(posedge clk);
      @(negedge clk);
      opcode = 4'd0; a = 16'd1; b = 16'd1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("busy%0d.in_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("busy%0d.busy", k), 64'(busy), 64'd1);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_out("busy");
      check("busy.result", 64'(result), 64'd12);
      @(negedge clk);

      // Reset in the middle of a multiply discards it.
      in_valid = 1'b1; opcode = 4'd4; a = 16'hFED4; b = 16'h00C8;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("mrst.out_valid", 64'(out_valid), 64'd0);
      check("mrst.busy", 64'(busy), 64'd0);
      check("mrst.result", 64'(result), 64'd0);
      check("mrst.overflow", 64'(overflow), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mrst.no_late_valid", 64'(seen), 64'd0);
      run_vec(99, '{16'd2, 16'd3, 4'd0, 32'd5, 16'd0, 1'b1, 1'b0, 1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
